// File: rtl/seven_seg_display_driver.sv
// Four-digit shift buffer of hex key codes driving a multiplexed common-anode seven-segment display.
// an/seg/count/full are registered; a buffer update reaches seg one edge after it reaches count.
module seven_seg_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       clear,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] count,
  output logic       full
);

  localparam int RW = $clog2(REFRESH_DIV);

  logic [3:0][3:0] d_q, d_d;
  logic [2:0]      count_q, count_d;
  logic            full_q, full_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  function automatic logic [6:0] encode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    d_d     = d_q;
    count_d = count_q;
    // clear takes priority and swallows a coincident strobe
    if (clear) begin
      count_d = 3'd0;
    end else if (digit_valid) begin
      d_d = {d_q[2], d_q[1], d_q[0], digit_in};
      if (count_q != 3'd4) count_d = count_q + 3'd1;
    end
    full_d = (count_d == 3'd4);
  end

  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    idx_d  = idx_q;
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // an and seg both derive from the same idx_q so they switch together
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = 7'b1111111;
    if ({1'b0, idx_q} < count_q) seg_d = encode(d_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      count_q <= 3'd0;
      full_q  <= 1'b0;
      rcnt_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      d_q     <= d_d;
      count_q <= count_d;
      full_q  <= full_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Bench for seven_seg_display_driver: queue-based display model, encoding table, directed corner cases, random traffic.
module tb_seven_seg_display_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] count;
  logic       full;

  seven_seg_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .an(an), .seg(seg), .dp(dp), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } enc_vec_t;

  enc_vec_t tab[16];

  int         n_vec = 0;
  int         n_bad = 0;
  int         ecnt  = 0;
  int         mq[$];
  logic [6:0] cap[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int pos);
    if (pos < mq.size()) return tab[mq[pos]].seg;
    return 7'b1111111;
  endfunction

  // One clock: predict the outputs from the model state before the edge, then advance the model.
  task automatic step();
    int         slot;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    slot  = (ecnt / DIV) % 4;
    e_an  = ~(4'b0001 << slot);
    e_seg = model_seg(slot);
    if (clear) mq.delete();
    else if (digit_valid) begin
      mq.push_front(int'(digit_in));
      if (mq.size() > 4) void'(mq.pop_back());
    end
    ecnt++;
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 4);
    chk("dp", dp, 1'b1);
  endtask

  task automatic idle();
    digit_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] v);
    digit_in = v; digit_valid = 1'b1; clear = 1'b0;
    step();
    idle();
  endtask

  task automatic run_frame();
    for (int i = 0; i < 4 * DIV; i++) begin
      step();
      for (int k = 0; k < 4; k++) if (an[k] == 1'b0) cap[k] = seg;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0]  = '{4'h0, 7'b1000000}; tab[1]  = '{4'h1, 7'b1111001};
    tab[2]  = '{4'h2, 7'b0100100}; tab[3]  = '{4'h3, 7'b0110000};
    tab[4]  = '{4'h4, 7'b0011001}; tab[5]  = '{4'h5, 7'b0010010};
    tab[6]  = '{4'h6, 7'b0000010}; tab[7]  = '{4'h7, 7'b1111000};
    tab[8]  = '{4'h8, 7'b0000000}; tab[9]  = '{4'h9, 7'b0010000};
    tab[10] = '{4'hA, 7'b0001000}; tab[11] = '{4'hB, 7'b0000011};
    tab[12] = '{4'hC, 7'b1000110}; tab[13] = '{4'hD, 7'b0100001};
    tab[14] = '{4'hE, 7'b0000110}; tab[15] = '{4'hF, 7'b0001110};

    rst_n = 1'b0; digit_in = 4'h0; idle();
    #12;
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_full", full, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ecnt = 0; mq.delete();

    // Empty display: scanning only, everything blank
    run_frame();
    for (int k = 0; k < 4; k++) chk("empty_slot", cap[k], 7'b1111111);

    // Fill with 1,2,3,4 back to back
    strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4);
    run_frame();
    chk("fill_slot0", cap[0], 7'b0011001);
    chk("fill_slot3", cap[3], 7'b1111001);
    chk("fill_count", count, 3'd4);
    chk("fill_full", full, 1'b1);

    // Append while full drops the oldest
    strobe(4'hA);
    run_frame();
    chk("ovf_slot0", cap[0], 7'b0001000);
    chk("ovf_slot3", cap[3], 7'b0100100);
    chk("ovf_count", count, 3'd4);

    // Single digit after clear
    clear = 1'b1; step(); idle();
    strobe(4'h7);
    run_frame();
    chk("one_slot0", cap[0], 7'b1111000);
    for (int k = 1; k < 4; k++) chk("one_blank", cap[k], 7'b1111111);
    chk("one_count", count, 3'd1);

    // Clear and strobe together with two digits held: clear wins
    strobe(4'h5);
    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'h9;
    step(); idle();
    chk("clrwin_count", count, 3'd0);
    run_frame();
    for (int k = 0; k < 4; k++) chk("clrwin_blank", cap[k], 7'b1111111);

    // Encoding table: each code shown alone in slot 0
    for (int i = 0; i < 16; i++) begin
      clear = 1'b1; step(); idle();
      strobe(tab[i].code);
      run_frame();
      chk("enc_slot0", cap[0], tab[i].seg);
      chk("enc_slot1", cap[1], 7'b1111111);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      digit_in    = 4'($urandom_range(0, 15));
      digit_valid = ($urandom_range(0, 2) == 0);
      clear       = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();

    // Asynchronous reset in the middle of slot 2
    strobe(4'h3); strobe(4'h8);
    while (((ecnt / DIV) % 4) != 2 || (ecnt % DIV) != 2) step();
    digit_in = 4'hC; digit_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'b1111);
    chk("arst_seg", seg, 7'b1111111);
    chk("arst_count", count, 3'd0);
    chk("arst_full", full, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("arst_hold_an", an, 4'b1111);
    rst_n = 1'b1;
    ecnt = 0; mq.delete();
    step();
    chk("arst_restart_an", an, 4'b1110);
    run_frame();
    for (int k = 0; k < 4; k++) chk("arst_blank", cap[k], 7'b1111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
